// File: rtl/acc_pkg.sv
// Shared accelerator definitions: default datapath widths and the fetch FSM encoding.
package acc_pkg;

  localparam int unsigned DEFAULT_INPUT_WIDTH  = 512;
  localparam int unsigned DEFAULT_OUTPUT_WIDTH = 64;
  localparam int unsigned DEFAULT_CNT_W        = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifm_fetch_ctrl_if.sv
// IFM fetch bundle: conv control, AXI-Stream beat input and parser-facing outputs.
interface ifm_fetch_ctrl_if #(
    parameter int unsigned INPUT_WIDTH = acc_pkg::DEFAULT_INPUT_WIDTH,
    parameter int unsigned CNT_W       = acc_pkg::DEFAULT_CNT_W
);

    logic                   conv_start;
    logic [CNT_W-1:0]       num_beats;
    logic [INPUT_WIDTH-1:0] s_axis_tdata;
    logic                   s_axis_tvalid;
    logic                   s_axis_tready;
    logic                   stall;
    logic [INPUT_WIDTH-1:0] fm_out;
    logic                   ifm_read;
    logic [5:0]             word_idx;
    logic                   busy;
    logic                   done;

    modport master (
        output conv_start, num_beats, s_axis_tdata, s_axis_tvalid, stall,
        input  s_axis_tready, fm_out, ifm_read, word_idx, busy, done
    );

    modport slave (
        input  conv_start, num_beats, s_axis_tdata, s_axis_tvalid, stall,
        output s_axis_tready, fm_out, ifm_read, word_idx, busy, done
    );

endinterface

// File: rtl/beat_fifo2.sv
// Two-entry registered FIFO for full-width IFM beats; head entry is always visible on dout.
module beat_fifo2
    import acc_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_INPUT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/ifm_fetch_ctrl.sv
// IFM fetch controller: accepts programmed number of AXIS beats and strobes the parser per sub-word.
module ifm_fetch_ctrl
    import acc_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH  = DEFAULT_INPUT_WIDTH,
    parameter int unsigned OUTPUT_WIDTH = DEFAULT_OUTPUT_WIDTH,
    parameter int unsigned CNT_W        = DEFAULT_CNT_W
) (
    input logic              clk,
    input logic              rst,
    ifm_fetch_ctrl_if.slave  bus
);

    localparam int unsigned MAX_CNT  = INPUT_WIDTH / OUTPUT_WIDTH;
    localparam logic [5:0]  LAST_IDX = 6'(MAX_CNT - 1);

    fetch_state_e           state;
    logic [CNT_W-1:0]       num_beats_q;
    logic [CNT_W-1:0]       beats_in;
    logic [CNT_W-1:0]       beats_out;
    logic [5:0]             word_idx;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [INPUT_WIDTH-1:0] fifo_dout;
    logic                   tready;
    logic                   push;
    logic                   read;
    logic                   pop;
    logic                   last_pop;

    // tready depends only on registered state so there is no path from tvalid
    assign tready   = (state == StRun) & ~fifo_full & (beats_in < num_beats_q);
    assign push     = bus.s_axis_tvalid & tready;
    assign read     = (state == StRun) & ~fifo_empty & ~bus.stall;
    assign pop      = read & (word_idx == LAST_IDX);
    assign last_pop = pop & ((beats_out + CNT_W'(1)) == num_beats_q);

    assign bus.s_axis_tready = tready;
    assign bus.ifm_read      = read;
    assign bus.word_idx      = word_idx;
    assign bus.fm_out        = fifo_dout;
    assign bus.busy          = (state == StRun) | (state == StDone);
    assign bus.done          = (state == StDone);

    beat_fifo2 #(
        .WIDTH (INPUT_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.s_axis_tdata),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            num_beats_q <= '0;
            beats_in    <= '0;
            beats_out   <= '0;
            word_idx    <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.conv_start) begin
                        num_beats_q <= bus.num_beats;
                        beats_in    <= '0;
                        beats_out   <= '0;
                        state       <= (bus.num_beats == '0) ? StDone : StRun;
                    end
                end
                StRun: begin
                    if (push) beats_in <= beats_in + CNT_W'(1);
                    if (pop) beats_out <= beats_out + CNT_W'(1);
                    if (read) word_idx <= (word_idx == LAST_IDX) ? 6'd0 : word_idx + 6'd1;
                    if (last_pop) state <= StDone;
                end
                StDone: begin
                    state     <= StIdle;
                    beats_in  <= '0;
                    beats_out <= '0;
                    word_idx  <= '0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
